// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
// MDOp values mirror the decoder's E-stage encoding; 3'b111 decodes as no-op.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 8;

  typedef enum logic {OP_MUL, OP_DIV} opClass_e;
  typedef enum logic {ST_IDLE, ST_RUN} mdState_e;

  function automatic logic isMulDiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_timer.sv
// Loadable busy-period down-counter; done pulses during the last busy cycle,
// which is the cycle whose closing edge commits the pending result.
module md_timer
  import md_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] loadVal_i,
  output logic             busy_o,
  output logic             done_o
);

  mdState_e         stateQ;
  logic [CNT_W-1:0] cntQ;
  logic             busyQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= ST_IDLE;
      cntQ   <= '0;
      busyQ  <= 1'b0;
    end else begin
      case (stateQ)
        ST_IDLE: begin
          if (load_i && (loadVal_i != '0)) begin
            stateQ <= ST_RUN;
            cntQ   <= loadVal_i;
            busyQ  <= 1'b1;
          end
        end
        ST_RUN: begin
          cntQ <= cntQ - CNT_W'(1);
          if (cntQ == CNT_W'(1)) begin
            stateQ <= ST_IDLE;
            busyQ  <= 1'b0;
          end
        end
        default: stateQ <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = busyQ;
  assign done_o = (stateQ == ST_RUN) && (cntQ == CNT_W'(1));

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit holding HI/LO. The result is computed at
// Start, parked in pending registers, and committed when the busy period ends.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic        accept, isDiv, sgnDiv, done;
  logic [63:0] mulA, mulB, prod;
  logic [31:0] absA, absB, divisor, uq, ur, resHi, resLo;
  logic [31:0] hiQ, hiD, loQ, loD, pHiQ, pHiD, pLoQ, pLoD;
  opClass_e    opClassQ, opClassD;
  logic        divZeroQ, divZeroD;

  assign accept = Start && !Busy && isMulDiv(MDOp);
  assign isDiv  = (MDOp == MD_DIV) || (MDOp == MD_DIVU);
  assign sgnDiv = (MDOp == MD_DIV);

  md_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept),
    .loadVal_i (isDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)),
    .busy_o    (Busy),
    .done_o    (done)
  );

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    mulA    = (MDOp == MD_MULT) ? {{32{A[31]}}, A} : {32'b0, A};
    mulB    = (MDOp == MD_MULT) ? {{32{B[31]}}, B} : {32'b0, B};
    prod    = mulA * mulB;
    absA    = (sgnDiv && A[31]) ? -A : A;
    absB    = (sgnDiv && B[31]) ? -B : B;
    divisor = (absB == 32'd0) ? 32'd1 : absB;
    uq      = absA / divisor;
    ur      = absA % divisor;
    if (isDiv) begin
      resLo = (sgnDiv && (A[31] ^ B[31])) ? -uq : uq;
      resHi = (sgnDiv && A[31]) ? -ur : ur;
    end else begin
      resHi = prod[63:32];
      resLo = prod[31:0];
    end
  end

  always_comb begin
    hiD      = hiQ;
    loD      = loQ;
    pHiD     = pHiQ;
    pLoD     = pLoQ;
    opClassD = opClassQ;
    divZeroD = divZeroQ;
    if (accept) begin
      pHiD     = resHi;
      pLoD     = resLo;
      opClassD = isDiv ? OP_DIV : OP_MUL;
      divZeroD = (B == 32'd0);
    end else if (done) begin
      if (!(opClassQ == OP_DIV && divZeroQ)) begin
        hiD = pHiQ;
        loD = pLoQ;
      end
    end else if (!Busy && MDOp == MD_MTHI) begin
      hiD = A;
    end else if (!Busy && MDOp == MD_MTLO) begin
      loD = A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hiQ      <= '0;
      loQ      <= '0;
      pHiQ     <= '0;
      pLoQ     <= '0;
      opClassQ <= OP_MUL;
      divZeroQ <= 1'b0;
    end else begin
      hiQ      <= hiD;
      loQ      <= loD;
      pHiQ     <= pHiD;
      pLoQ     <= pLoD;
      opClassQ <= opClassD;
      divZeroQ <= divZeroD;
    end
  end

  assign HI = hiQ;
  assign LO = loQ;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a cycle model built on 64-bit integer
// arithmetic is compared every cycle, plus literal checks of known results.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  int                mLeft = 0;
  logic [31:0]       mHi = '0, mLo = '0, mPHi = '0, mPLo = '0;
  bit                mPendOk = 0;
  longint            sa, sb, sres;
  longint unsigned   ua, ub, ures;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDOp  (MDOp),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  // Reference behaviour: busy countdown and HI/LO from plain integer arithmetic.
  always @(posedge clk) begin
    if (reset) begin
      mLeft = 0; mHi = '0; mLo = '0; mPendOk = 0;
    end else if (mLeft > 0) begin
      mLeft = mLeft - 1;
      if (mLeft == 0 && mPendOk) begin
        mHi = mPHi;
        mLo = mPLo;
      end
    end else if (Start && (MDOp == MD_MULT || MDOp == MD_MULTU ||
                           MDOp == MD_DIV  || MDOp == MD_DIVU)) begin
      sa = $signed(A); sb = $signed(B);
      ua = A;          ub = B;
      mPendOk = 1;
      case (MDOp)
        MD_MULT:  begin sres = sa * sb; mPHi = 32'(sres >>> 32); mPLo = 32'(sres); mLeft = 5; end
        MD_MULTU: begin ures = ua * ub; mPHi = 32'(ures >> 32); mPLo = 32'(ures); mLeft = 5; end
        MD_DIV: begin
          mLeft = 10;
          if (B == 32'd0) mPendOk = 0;
          else begin mPLo = 32'(sa / sb); mPHi = 32'(sa % sb); end
        end
        default: begin
          mLeft = 10;
          if (B == 32'd0) mPendOk = 0;
          else begin mPLo = 32'(ua / ub); mPHi = 32'(ua % ub); end
        end
      endcase
    end else if (MDOp == MD_MTHI) begin
      mHi = A;
    end else if (MDOp == MD_MTLO) begin
      mLo = A;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      check("cyc_busy", {31'b0, Busy}, {31'b0, (mLeft > 0)});
      check("cyc_hi", HI, mHi);
      check("cyc_lo", LO, mLo);
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic st);
    MDOp = op; A = a; B = b; Start = st;
    @(negedge clk);
    MDOp = MD_NONE; A = '0; B = '0; Start = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expHi, input logic [31:0] expLo);
    check({name, "_hi"}, HI, expHi);
    check({name, "_lo"}, LO, expLo);
    check({name, "_model_hi"}, mHi, expHi);
    check({name, "_model_lo"}, mLo, expLo);
  endtask

  task automatic waitIdle(input string name, input int expCycles);
    int n = 0;
    while (Busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout actual=%0d expected=%0d", name, n, expCycles);
    end else begin
      check({name, "_busycycles"}, 32'(n), 32'(expCycles));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; A = '0; B = '0; MDOp = MD_NONE; Start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkEn = 1;
    check("rst_busy", {31'b0, Busy}, 32'd0);
    checkOutput("rst", 32'h0, 32'h0);

    applyStimulus(MD_MULT, 32'hFFFFFFFE, 32'h00000003, 1'b1);
    waitIdle("mult", 5);
    checkOutput("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

    applyStimulus(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    waitIdle("multu", 5);
    checkOutput("multu", 32'hFFFFFFFE, 32'h00000001);
    applyStimulus(MD_DIVU, 32'd100, 32'd7, 1'b1);
    waitIdle("divu_b2b", 10);
    checkOutput("divu_b2b", 32'd2, 32'd14);

    applyStimulus(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
    waitIdle("div_neg", 10);
    checkOutput("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);

    applyStimulus(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    waitIdle("div_ovf", 10);
    checkOutput("div_ovf", 32'h0, 32'h80000000);

    applyStimulus(MD_MTHI, 32'h1111, 32'h0, 1'b0);
    applyStimulus(MD_MTLO, 32'h2222, 32'h0, 1'b0);
    checkOutput("mt_pre", 32'h1111, 32'h2222);
    applyStimulus(MD_DIVU, 32'h12345678, 32'h0, 1'b1);
    waitIdle("divz", 10);
    checkOutput("divz", 32'h1111, 32'h2222);

    applyStimulus(MD_MULT, 32'd3, 32'd4, 1'b1);
    applyStimulus(MD_MTHI, 32'hDEAD, 32'h0, 1'b0);
    applyStimulus(MD_DIV, 32'd100, 32'd3, 1'b1);
    waitIdle("busy_ignore", 3);
    checkOutput("busy_ignore", 32'h0, 32'd12);

    applyStimulus(MD_MTHI, 32'h5555, 32'h0, 1'b1);
    check("start_mthi_busy", {31'b0, Busy}, 32'd0);
    applyStimulus(3'b111, 32'd9, 32'd9, 1'b1);
    check("start_op7_busy", {31'b0, Busy}, 32'd0);
    applyStimulus(MD_MTLO, 32'hBEEF, 32'h0, 1'b0);
    checkOutput("mtlo", 32'h5555, 32'hBEEF);

    applyStimulus(MD_DIV, 32'd100, 32'd3, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {31'b0, Busy}, 32'd0);
    checkOutput("midrst", 32'h0, 32'h0);
    repeat (8) @(negedge clk);
    check("midrst_late_busy", {31'b0, Busy}, 32'd0);
    checkOutput("midrst_late", 32'h0, 32'h0);

    checkEn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
